keypad_event_tracker: RTL and testbench

// - Successor to the single-key numeric-keypad decoder.
// - Tracks every keypad key held at once as a bitmap and keeps a "last held key" output.
// - Queues press/repeat events in a show-ahead FIFO so game/UI logic can consume keys at its own pace.
// - Sits between the PS/2 keyboard front end (keyCode/make/brakee) and the game controllers.

---
 rtl/keypad_event_tracker_if.sv | 42 ++++
 rtl/keypad_event_tracker.sv | 247 ++++++++++++++++++++++++
 tb/tb_keypad_event_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_event_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_event_tracker_if
// Brief    : Bundle of key-event inputs and key/event-FIFO outputs shared
//            between the PS/2 front end / game logic and the tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_event_tracker_if #(
    parameter int NUM_KEYS = 16
);
    // Scan code and pulses from the PS/2 front end, plus consumer controls
    logic [8:0]          keyCode;
    logic                make;
    logic                brakee;
    logic                rd_en;
    logic                clr_overflow;

    // Held-key state and head of the event queue
    logic [3:0]          key;
    logic                keyIsValid;
    logic [NUM_KEYS-1:0] keysDown;
    logic                evt_valid;
    logic [3:0]          evt_key;
    logic                evt_repeat;
    logic                fifo_full;
    logic                overflow;

    // Driver side: front end and event consumer
    modport master (
        output keyCode, make, brakee, rd_en, clr_overflow,
        input  key, keyIsValid, keysDown, evt_valid, evt_key,
               evt_repeat, fifo_full, overflow
    );

    // Tracker side
    modport slave (
        input  keyCode, make, brakee, rd_en, clr_overflow,
        output key, keyIsValid, keysDown, evt_valid, evt_key,
               evt_repeat, fifo_full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/keypad_event_tracker.sv
`default_nettype none
// ============================================================================
// Module   : keypad_event_tracker
// Brief    : Numeric-keypad tracker. Decodes PS/2 make/break codes into a
//            held-key bitmap and a "last held key", and queues press (and,
//            optionally, auto-repeat) events in a show-ahead FIFO.
//            Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat events).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_event_tracker #(
    parameter int NUM_KEYS     = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    keypad_event_tracker_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(FIFO_DEPTH);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Entry = {repeat, key}
    localparam int c_entry_w = 5;
`else
    // Entry = key only; repeat events never exist in this build
    localparam int c_entry_w = 4;
`endif

    // Reject configurations the key field or pointer arithmetic cannot honour
    if ((NUM_KEYS < 1) || (NUM_KEYS > 16) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_params
        $error("keypad_event_tracker: unsupported parameter set");
    end

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [3:0]           w_code_idx;
    logic                 w_code_hit;
    logic                 w_code_valid;
    logic [15:0]          w_mask16;
    logic [NUM_KEYS-1:0]  w_key_mask;
    logic [15:0]          w_down16;
    logic                 w_is_down;
    logic                 w_press;
    logic                 w_release;

    logic [NUM_KEYS-1:0]  r_keys_down;
    logic [3:0]           r_key;
    logic                 r_key_valid;

    logic                 w_push;
    logic [c_entry_w-1:0] w_push_data;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_drop;
    logic [c_entry_w-1:0] w_head;

    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_addr_w:0]    r_count;
    logic                 r_overflow;

    // ------------------------------------------------------------------------
    // Scan-code decode
    // ------------------------------------------------------------------------
    // Map the 9-bit scan code (bit 8 = E0 prefix) onto a key index
    always_comb begin
        w_code_idx = 4'd0;
        w_code_hit = 1'b0;
        case (bus.keyCode)
            9'h070: begin w_code_idx = 4'd0;  w_code_hit = 1'b1; end
            9'h069: begin w_code_idx = 4'd1;  w_code_hit = 1'b1; end
            9'h072: begin w_code_idx = 4'd2;  w_code_hit = 1'b1; end
            9'h07A: begin w_code_idx = 4'd3;  w_code_hit = 1'b1; end
            9'h06B: begin w_code_idx = 4'd4;  w_code_hit = 1'b1; end
            9'h073: begin w_code_idx = 4'd5;  w_code_hit = 1'b1; end
            9'h074: begin w_code_idx = 4'd6;  w_code_hit = 1'b1; end
            9'h06C: begin w_code_idx = 4'd7;  w_code_hit = 1'b1; end
            9'h075: begin w_code_idx = 4'd8;  w_code_hit = 1'b1; end
            9'h07D: begin w_code_idx = 4'd9;  w_code_hit = 1'b1; end
            9'h077: begin w_code_idx = 4'd10; w_code_hit = 1'b1; end
            9'h14A: begin w_code_idx = 4'd11; w_code_hit = 1'b1; end
            9'h07C: begin w_code_idx = 4'd12; w_code_hit = 1'b1; end
            9'h07B: begin w_code_idx = 4'd13; w_code_hit = 1'b1; end
            9'h079: begin w_code_idx = 4'd14; w_code_hit = 1'b1; end
            9'h071: begin w_code_idx = 4'd15; w_code_hit = 1'b1; end
            default: begin
                w_code_idx = 4'd0;
                w_code_hit = 1'b0;
            end
        endcase
    end

    // Keys beyond NUM_KEYS are treated like unknown codes
    assign w_code_valid = w_code_hit && ({28'd0, w_code_idx} < 32'(NUM_KEYS));
    assign w_mask16     = 16'd1 << w_code_idx;
    assign w_key_mask   = w_mask16[NUM_KEYS-1:0];
    assign w_down16     = 16'(r_keys_down);
    assign w_is_down    = w_down16[w_code_idx];

    // A simultaneous make+break is a break; typematic makes are swallowed
    assign w_release = bus.brakee && w_code_valid && w_is_down;
    assign w_press   = bus.make && !bus.brakee && w_code_valid && !w_is_down;

    // ------------------------------------------------------------------------
    // Held-key state
    // ------------------------------------------------------------------------
    // Track the bitmap and the most recently pressed key still held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_down <= '0;
            r_key       <= 4'd0;
            r_key_valid <= 1'b0;
        end else if (w_press) begin
            r_keys_down <= r_keys_down | w_key_mask;
            r_key       <= w_code_idx;
            r_key_valid <= 1'b1;
        end else if (w_release) begin
            r_keys_down <= r_keys_down & ~w_key_mask;
            // Releasing the current key drops valid but keeps its number
            if (w_code_idx == r_key) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event source: press events, plus auto-repeat when enabled
    // ------------------------------------------------------------------------
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cnt_w   = ($clog2(c_rep_max) > 0) ? $clog2(c_rep_max) : 1;
    localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);

    logic [c_cnt_w-1:0] r_rep_cnt;
    logic               r_rep_first;
    logic               w_rep_due;

    // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_RATE cycles
    assign w_rep_due = r_key_valid &&
                       ((r_rep_first  && (r_rep_cnt == c_delay_last)) ||
                        (!r_rep_first && (r_rep_cnt == c_rate_last)));

    // Hold-time counter, restarted by a fresh press or by losing the key
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_press || !r_key_valid) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_due) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else begin
            r_rep_cnt   <= r_rep_cnt + c_cnt_w'(1);
        end
    end

    // A press due in the same cycle as a repeat takes the single push slot
    assign w_push      = w_press || w_rep_due;
    assign w_push_data = w_press ? {1'b0, w_code_idx} : {1'b1, r_key};
`else
    assign w_push      = w_press;
    assign w_push_data = w_code_idx;
`endif

    // ------------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    assign w_pop   = bus.rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Storage array; contents are only observed when the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a drop in the clearing cycle keeps it set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_head         = r_mem[r_rd_ptr];
    assign bus.key        = r_key;
    assign bus.keyIsValid = r_key_valid;
    assign bus.keysDown   = r_keys_down;
    assign bus.evt_valid  = !w_empty;
    assign bus.evt_key    = w_empty ? 4'd0 : w_head[3:0];
`ifdef KEYPAD_AUTOREPEAT_EN
    assign bus.evt_repeat = !w_empty && w_head[4];
`else
    assign bus.evt_repeat = 1'b0;
`endif
    assign bus.fifo_full  = w_full;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_event_tracker
// Brief    : Self-checking bench for keypad_event_tracker: a vector table for
//            decode/bitmap/FIFO behaviour plus sequences for auto-repeat
//            timing and reset in mid-operation.
//            Honours KEYPAD_AUTOREPEAT_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_event_tracker;

    localparam int NK = 16;
    localparam int FD = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    keypad_event_tracker_if #(.NUM_KEYS(NK)) bus ();

    keypad_event_tracker #(
        .NUM_KEYS     (NK),
        .FIFO_DEPTH   (FD),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       mk;
        logic       bk;
        logic [8:0] code;
        logic       rd;
        logic       clr;
        logic [3:0] key;
        logic       kv;
        logic [15:0] kd;
        logic       ev;
        logic [3:0] ek;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic mk, input logic bk, input logic [8:0] code,
                                 input logic rd, input logic clr,
                                 input logic [3:0] key, input logic kv, input logic [15:0] kd,
                                 input logic ev, input logic [3:0] ek,
                                 input logic full, input logic ovf);
        vec_t v;
        v.mk = mk; v.bk = bk; v.code = code; v.rd = rd; v.clr = clr;
        v.key = key; v.kv = kv; v.kd = kd; v.ev = ev; v.ek = ek;
        v.full = full; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] k, input logic kv,
                             input logic [15:0] kd, input logic ev, input logic [3:0] ek,
                             input logic er, input logic full, input logic ovf);
        chk({tag, ".key"},        32'(bus.key),        32'(k));
        chk({tag, ".keyIsValid"}, 32'(bus.keyIsValid), 32'(kv));
        chk({tag, ".keysDown"},   32'(bus.keysDown),   32'(kd));
        chk({tag, ".evt_valid"},  32'(bus.evt_valid),  32'(ev));
        chk({tag, ".evt_key"},    32'(bus.evt_key),    32'(ek));
        chk({tag, ".evt_repeat"}, 32'(bus.evt_repeat), 32'(er));
        chk({tag, ".fifo_full"},  32'(bus.fifo_full),  32'(full));
        chk({tag, ".overflow"},   32'(bus.overflow),   32'(ovf));
    endtask

    // One clock of stimulus: drive on the falling edge, sample 1 after rising
    task automatic step(input logic mk, input logic bk, input logic [8:0] code,
                        input logic rd, input logic clr);
        @(negedge clk);
        bus.make = mk; bus.brakee = bk; bus.keyCode = code;
        bus.rd_en = rd; bus.clr_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.make = 1'b0; bus.brakee = 1'b0; bus.keyCode = 9'h000;
        bus.rd_en = 1'b0; bus.clr_overflow = 1'b0;
        @(posedge clk);
        #1;
        chk_state(tag, 4'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int  N_HOLD_EVT = 4;
    localparam logic HOLD_FULL = 1'b1;
`else
    localparam int  N_HOLD_EVT = 1;
    localparam logic HOLD_FULL = 1'b0;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.make = 1'b0; bus.brakee = 1'b0; bus.keyCode = 9'h000;
        bus.rd_en = 1'b0; bus.clr_overflow = 1'b0;

        //            mk bk code    rd clr | key kv kd       ev ek full ovf
        tbl.push_back(mkv(1,0,9'h070,0,0,  4'd0, 1,16'h0001,1,4'd0, 0,0)); // press 0
        tbl.push_back(mkv(0,1,9'h070,0,0,  4'd0, 0,16'h0000,1,4'd0, 0,0)); // release 0
        tbl.push_back(mkv(1,0,9'h069,0,0,  4'd1, 1,16'h0002,1,4'd0, 0,0)); // press 1
        tbl.push_back(mkv(1,0,9'h072,0,0,  4'd2, 1,16'h0006,1,4'd0, 0,0)); // press 2
        tbl.push_back(mkv(0,1,9'h072,0,0,  4'd2, 0,16'h0002,1,4'd0, 0,0)); // release current
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd2, 0,16'h0002,1,4'd1, 0,0)); // pop -> 1
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd2, 0,16'h0002,1,4'd2, 0,0)); // pop -> 2
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd2, 0,16'h0002,0,4'd0, 0,0)); // pop -> empty
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd2, 0,16'h0002,0,4'd0, 0,0)); // pop when empty
        tbl.push_back(mkv(1,0,9'h14A,0,0,  4'd11,1,16'h0802,1,4'd11,0,0)); // extended key
        tbl.push_back(mkv(1,0,9'h04A,0,0,  4'd11,1,16'h0802,1,4'd11,0,0)); // unextended: none
        tbl.push_back(mkv(1,0,9'h1F0,0,0,  4'd11,1,16'h0802,1,4'd11,0,0)); // unknown code
        tbl.push_back(mkv(1,0,9'h14A,0,0,  4'd11,1,16'h0802,1,4'd11,0,0)); // typematic
        tbl.push_back(mkv(1,1,9'h070,0,0,  4'd11,1,16'h0802,1,4'd11,0,0)); // mk+bk, not down
        tbl.push_back(mkv(0,1,9'h069,0,0,  4'd11,1,16'h0800,1,4'd11,0,0)); // release non-current
        tbl.push_back(mkv(1,1,9'h14A,0,0,  4'd11,0,16'h0000,1,4'd11,0,0)); // mk+bk = break
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd11,0,16'h0000,0,4'd0, 0,0)); // drain
        tbl.push_back(mkv(1,0,9'h07A,0,0,  4'd3, 1,16'h0008,1,4'd3, 0,0));
        tbl.push_back(mkv(1,0,9'h06B,0,0,  4'd4, 1,16'h0018,1,4'd3, 0,0));
        tbl.push_back(mkv(1,0,9'h073,0,0,  4'd5, 1,16'h0038,1,4'd3, 0,0));
        tbl.push_back(mkv(1,0,9'h074,0,0,  4'd6, 1,16'h0078,1,4'd3, 1,0)); // full
        tbl.push_back(mkv(1,0,9'h06C,0,0,  4'd7, 1,16'h00F8,1,4'd3, 1,1)); // drop
        tbl.push_back(mkv(1,0,9'h075,1,0,  4'd8, 1,16'h01F8,1,4'd4, 1,1)); // push+pop full
        tbl.push_back(mkv(1,0,9'h07D,0,1,  4'd9, 1,16'h03F8,1,4'd4, 1,1)); // drop beats clear
        tbl.push_back(mkv(0,0,9'h000,0,1,  4'd9, 1,16'h03F8,1,4'd4, 1,0)); // clear
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd9, 1,16'h03F8,1,4'd5, 0,0));
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd9, 1,16'h03F8,1,4'd6, 0,0));
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd9, 1,16'h03F8,1,4'd8, 0,0));
        tbl.push_back(mkv(0,0,9'h000,1,0,  4'd9, 1,16'h03F8,0,4'd0, 0,0));

        // Initial reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 4'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].mk, tbl[i].bk, tbl[i].code, tbl[i].rd, tbl[i].clr);
            chk_state($sformatf("vec%0d", i), tbl[i].key, tbl[i].kv, tbl[i].kd,
                      tbl[i].ev, tbl[i].ek, 1'b0, tbl[i].full, tbl[i].ovf);
        end

        // Hold key 5 for 31 cycles, then read back the queued events
        do_reset("rstA");
        step(1'b1, 1'b0, 9'h073, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 9'h073, 1'b0, 1'b0);
        chk_state("hold", 4'd5, 1'b0, 16'h0000, 1'b1, 4'd5, 1'b0, HOLD_FULL, 1'b0);
        for (int j = 0; j < N_HOLD_EVT; j++) begin
            chk($sformatf("hold_evt%0d.valid", j),  32'(bus.evt_valid),  32'd1);
            chk($sformatf("hold_evt%0d.key", j),    32'(bus.evt_key),    32'd5);
            chk($sformatf("hold_evt%0d.repeat", j), 32'(bus.evt_repeat), (j == 0) ? 32'd0 : 32'd1);
            step(1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
        end
        chk("hold_drained.valid", 32'(bus.evt_valid), 32'd0);

        // Reset while three keys are held and two events are queued
        do_reset("rstB");
        step(1'b1, 1'b0, 9'h070, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h069, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h072, 1'b0, 1'b0);
        step(1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
        chk_state("busy", 4'd2, 1'b1, 16'h0007, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        do_reset("rst_mid");
        step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        chk_state("post_rst", 4'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'h07A, 1'b0, 1'b0);
        chk_state("post_rst_press", 4'd3, 1'b1, 16'h0008, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
